// File: rtl/res_arb_pkg.sv
// res_arb_pkg -- shared definitions for the result-memory arbiter.
//   AW_DEF / DW_DEF : default address / data width of the result memory
//   MAX_LOCK_DEF    : default lock-guard limit (grants in a row while the
//                     other requester waits)
//   owner_t         : owner FSM state (IDLE = no owner, OWN0, OWN1)
package res_arb_pkg;

   localparam int unsigned AW_DEF       = 14;
   localparam int unsigned DW_DEF       = 8;
   localparam int unsigned MAX_LOCK_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } owner_t;

endpackage

// File: rtl/res_arb_owner.sv
// res_arb_owner -- ownership FSM, round-robin pointer and lock guard.
//   clk, reset          : clock, synchronous active-low reset
//   req0/req1           : requests
//   lock0/lock1         : keep-ownership requests
//   gnt0/gnt1           : grants issued by the top level (handshake = req & gnt)
//   owner               : current owner state
//   rr                  : round-robin pointer (0 = requester 0 wins a tie)
// Build option: define RES_ARB_LOCK_GUARD_EN to bound how long a locked
// owner can starve the other requester (limit MAX_LOCK, 1..15).
module res_arb_owner
   import res_arb_pkg::*;
#(
   parameter int unsigned MAX_LOCK = MAX_LOCK_DEF
)(
   input  logic   clk,
   input  logic   reset,
   input  logic   req0,
   input  logic   req1,
   input  logic   lock0,
   input  logic   lock1,
   input  logic   gnt0,
   input  logic   gnt1,
   output owner_t owner,
   output logic   rr
);

   logic hs0, hs1;
   logic win_lock, win_oth_req;
   logic own_req, own_lock, own_hs, oth_req;

   assign hs0 = req0 & gnt0;
   assign hs1 = req1 & gnt1;

   // Signals of the handshake winner (IDLE) and of the current owner (OWNn).
   always_comb begin
      win_lock    = hs1 ? lock1 : lock0;
      win_oth_req = hs1 ? req0  : req1;
      own_req     = req0;
      own_lock    = lock0;
      own_hs      = hs0;
      oth_req     = req1;
      if (owner == OWN1) begin
         own_req  = req1;
         own_lock = lock1;
         own_hs   = hs1;
         oth_req  = req0;
      end
   end

`ifdef RES_ARB_LOCK_GUARD_EN
   localparam logic [3:0] LIMIT = 4'(MAX_LOCK);
   logic [3:0] lock_cnt;
   logic [3:0] cnt_next;
   assign cnt_next = lock_cnt + 4'd1;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         owner <= IDLE;
         rr    <= 1'b0;
`ifdef RES_ARB_LOCK_GUARD_EN
         lock_cnt <= '0;
`endif
      end else begin
         case (owner)
            IDLE: begin
               if (hs0 || hs1) begin
                  rr <= hs0;
                  if (win_lock) begin
`ifdef RES_ARB_LOCK_GUARD_EN
                     // The grant that takes ownership already counts as the
                     // first one in the run, so the count starts at 1 here.
                     if (!(win_oth_req && LIMIT == 4'd1)) begin
                        owner    <= hs0 ? OWN0 : OWN1;
                        lock_cnt <= {3'b000, win_oth_req};
                     end
`else
                     owner <= hs0 ? OWN0 : OWN1;
`endif
                  end
               end
            end
            OWN0, OWN1: begin
               if (own_hs) begin
`ifdef RES_ARB_LOCK_GUARD_EN
                  if (oth_req && cnt_next == LIMIT) begin
                     owner    <= IDLE;
                     rr       <= (owner == OWN0);
                     lock_cnt <= '0;
                  end else if (!own_lock) begin
                     owner    <= IDLE;
                     lock_cnt <= '0;
                  end else begin
                     lock_cnt <= oth_req ? cnt_next : '0;
                  end
`else
                  if (!own_lock) owner <= IDLE;
`endif
               end else if (!own_req && !own_lock) begin
                  owner <= IDLE;
`ifdef RES_ARB_LOCK_GUARD_EN
                  lock_cnt <= '0;
`endif
               end
            end
            default: owner <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/res_mem_arbiter.sv
// res_mem_arbiter -- two-requester arbiter in front of a single-port
// result memory, with lock (ownership) support.
//   clk, reset            : clock, synchronous active-low reset
//   reqN/weN/lockN        : request, write(1)/read(0), keep ownership
//   addrN/wdataN          : access address / write data
//   gntN                  : combinational accept (handshake = reqN & gntN)
//   rvalidN/rdataN        : one-cycle read-data pulse, two edges after handshake
//   res_rd/res_wr         : memory strobes, one cycle per handshake
//   res_addr/res_do       : memory address / write data (hold when idle)
//   res_di                : memory read data, sampled one edge after res_rd
// Build option: RES_ARB_LOCK_GUARD_EN enables the lock guard in res_arb_owner.
module res_mem_arbiter
   import res_arb_pkg::*;
#(
   parameter int unsigned AW       = AW_DEF,
   parameter int unsigned DW       = DW_DEF,
   parameter int unsigned MAX_LOCK = MAX_LOCK_DEF
)(
   input  logic          clk,
   input  logic          reset,
   input  logic          req0,
   input  logic          req1,
   input  logic          we0,
   input  logic          we1,
   input  logic          lock0,
   input  logic          lock1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   output logic          gnt0,
   output logic          gnt1,
   output logic          rvalid0,
   output logic          rvalid1,
   output logic [DW-1:0] rdata0,
   output logic [DW-1:0] rdata1,
   output logic          res_rd,
   output logic          res_wr,
   output logic [AW-1:0] res_addr,
   output logic [DW-1:0] res_do,
   input  logic [DW-1:0] res_di
);

   owner_t owner;
   logic   rr;
   logic   hs0, hs1;
   logic   rd_sel;   // requester whose read is currently on the memory port

   res_arb_owner #(.MAX_LOCK(MAX_LOCK)) u_owner (
      .clk   (clk),
      .reset (reset),
      .req0  (req0),
      .req1  (req1),
      .lock0 (lock0),
      .lock1 (lock1),
      .gnt0  (gnt0),
      .gnt1  (gnt1),
      .owner (owner),
      .rr    (rr)
   );

   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (reset) begin
         case (owner)
            IDLE: begin
               gnt0 = req0 & (~req1 | ~rr);
               gnt1 = req1 & (~req0 |  rr);
            end
            OWN0:    gnt0 = req0;
            OWN1:    gnt1 = req1;
            default: ;
         endcase
      end
   end

   assign hs0 = req0 & gnt0;
   assign hs1 = req1 & gnt1;

   always_ff @(posedge clk) begin
      if (!reset) begin
         res_rd   <= 1'b0;
         res_wr   <= 1'b0;
         res_addr <= '0;
         res_do   <= '0;
         rd_sel   <= 1'b0;
         rvalid0  <= 1'b0;
         rvalid1  <= 1'b0;
         rdata0   <= '0;
         rdata1   <= '0;
      end else begin
         rvalid0 <= res_rd & ~rd_sel;
         rvalid1 <= res_rd &  rd_sel;
         if (res_rd && !rd_sel) rdata0 <= res_di;
         if (res_rd &&  rd_sel) rdata1 <= res_di;

         if (hs0 || hs1) begin
            res_rd   <= hs1 ? ~we1   : ~we0;
            res_wr   <= hs1 ?  we1   :  we0;
            res_addr <= hs1 ? addr1  : addr0;
            res_do   <= hs1 ? wdata1 : wdata0;
            rd_sel   <= hs1;
         end else begin
            res_rd <= 1'b0;
            res_wr <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_res_mem_arbiter.sv
module tb_res_mem_arbiter;

   localparam int AW       = 14;
   localparam int DW       = 8;
   localparam int MAX_LOCK = 8;
   localparam int NVEC     = 11;

   logic          clk = 1'b0;
   logic          reset;
   logic          req0, req1, we0, we1, lock0, lock1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic          gnt0, gnt1, rvalid0, rvalid1;
   logic [DW-1:0] rdata0, rdata1;
   logic          res_rd, res_wr;
   logic [AW-1:0] res_addr;
   logic [DW-1:0] res_do, res_di;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   res_mem_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(MAX_LOCK)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .lock0(lock0), .lock1(lock1), .addr0(addr0), .addr1(addr1),
      .wdata0(wdata0), .wdata1(wdata1), .gnt0(gnt0), .gnt1(gnt1),
      .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
      .res_rd(res_rd), .res_wr(res_wr), .res_addr(res_addr), .res_do(res_do),
      .res_di(res_di)
   );

   // Result memory device: combinational read, write on the strobe edge.
   logic [DW-1:0] dev_mem [0:(1<<AW)-1];
   always @(posedge clk) if (res_wr) dev_mem[res_addr] <= res_do;
   assign res_di = dev_mem[res_addr];

   // ---------------- reference model ----------------
   logic [DW-1:0] ref_mem [0:(1<<AW)-1];
   int            m_owner;    // -1 = nobody, else owning requester
   int            m_rr;
   int            m_streak;   // grants in a row to the owner while the other waits
   bit            m_known = 1'b0;
   logic          e_rd, e_wr, e_rv0, e_rv1;
   logic [AW-1:0] e_addr;
   logic [DW-1:0] e_do, e_rdata0, e_rdata1;
   bit            p_valid;
   int            p_who;
   logic [DW-1:0] p_data;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic logic [1:0] model_gnt();
      logic [1:0] g;
      logic       rq [2];
      g = 2'b00;
      rq[0] = req0;
      rq[1] = req1;
      if (reset) begin
         if (m_owner < 0) begin
            if (req0 && req1) g[m_rr] = 1'b1;
            else              g = {req1, req0};
         end else begin
            g[m_owner] = rq[m_owner];
         end
      end
      return g;
   endfunction

   function automatic void model_edge(input logic [1:0] g);
      int            win, o;
      logic          rq [2];
      logic          lk [2];
      logic          w;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      rq[0] = req0;  rq[1] = req1;
      lk[0] = lock0; lk[1] = lock1;
      if (!reset) begin
         m_owner = -1; m_rr = 0; m_streak = 0; m_known = 1'b1;
         e_rd = 0; e_wr = 0; e_addr = '0; e_do = '0;
         e_rv0 = 0; e_rv1 = 0; e_rdata0 = '0; e_rdata1 = '0;
         p_valid = 0;
         return;
      end
      e_rv0 = p_valid && p_who == 0;
      e_rv1 = p_valid && p_who == 1;
      if (e_rv0) e_rdata0 = p_data;
      if (e_rv1) e_rdata1 = p_data;
      p_valid = 0;
      win = (req0 && g[0]) ? 0 : ((req1 && g[1]) ? 1 : -1);
      if (win >= 0) begin
         w = (win == 0) ? we0 : we1;
         a = (win == 0) ? addr0 : addr1;
         d = (win == 0) ? wdata0 : wdata1;
         e_rd = !w; e_wr = w; e_addr = a; e_do = d;
         if (w) ref_mem[a] = d;
         else begin p_valid = 1; p_who = win; p_data = ref_mem[a]; end
      end else begin
         e_rd = 0; e_wr = 0;
      end
      if (m_owner < 0) begin
         if (win >= 0) begin
            m_rr = 1 - win;
            if (lk[win]) begin
               m_owner  = win;
               m_streak = rq[1-win] ? 1 : 0;
`ifdef RES_ARB_LOCK_GUARD_EN
               if (m_streak >= MAX_LOCK) begin m_owner = -1; m_streak = 0; end
`endif
            end
         end
      end else begin
         o = m_owner;
         if (win == o) begin
            m_streak = rq[1-o] ? m_streak + 1 : 0;
            if (!lk[o]) begin m_owner = -1; m_streak = 0; end
`ifdef RES_ARB_LOCK_GUARD_EN
            else if (m_streak >= MAX_LOCK) begin m_owner = -1; m_streak = 0; m_rr = 1 - o; end
`endif
         end else if (!rq[o] && !lk[o]) begin
            m_owner = -1; m_streak = 0;
         end
      end
   endfunction

   // One clock: check at the falling edge, advance the model at the rising edge.
   task automatic step();
      logic [1:0] g;
      @(negedge clk);
      g = model_gnt();
      check("gnt0", 32'(gnt0), 32'(g[0]));
      check("gnt1", 32'(gnt1), 32'(g[1]));
      if (m_known) begin
         check("res_rd",   32'(res_rd),   32'(e_rd));
         check("res_wr",   32'(res_wr),   32'(e_wr));
         check("res_addr", 32'(res_addr), 32'(e_addr));
         check("res_do",   32'(res_do),   32'(e_do));
         check("rvalid0",  32'(rvalid0),  32'(e_rv0));
         check("rvalid1",  32'(rvalid1),  32'(e_rv1));
         if (e_rv0) check("rdata0", 32'(rdata0), 32'(e_rdata0));
         if (e_rv1) check("rdata1", 32'(rdata1), 32'(e_rdata1));
      end
      @(posedge clk);
      model_edge(g);
      #1;
   endtask

   task automatic idle_in();
      req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
   endtask

   typedef struct {
      logic          q0, q1, w0, w1, l0, l1;
      logic [AW-1:0] a0, a1;
      logic [DW-1:0] d0, d1;
      logic          g0, g1;
   } vec_t;

   vec_t vt [NVEC];
   int   n0;
   bit   saw1;

   initial begin
      for (int i = 0; i < (1 << AW); i++) begin
         dev_mem[i] = 8'(i * 37 + 11);
         ref_mem[i] = 8'(i * 37 + 11);
      end
      //            q0 q1 w0 w1 l0 l1 a0   a1   d0 d1 g0 g1
      vt[0]  = '{1, 1, 0, 0, 0, 0, 100, 200, 0, 0, 1, 0};
      vt[1]  = '{1, 1, 0, 0, 0, 0, 100, 200, 0, 0, 0, 1};
      vt[2]  = '{0, 0, 0, 0, 0, 0, 0,   0,   0, 0, 0, 0};
      vt[3]  = '{0, 0, 0, 0, 0, 0, 0,   0,   0, 0, 0, 0};
      vt[4]  = '{1, 1, 0, 0, 1, 0, 10,  20,  0, 0, 1, 0};
      vt[5]  = '{1, 1, 1, 0, 1, 0, 11,  20,  3, 0, 1, 0};
      vt[6]  = '{1, 1, 0, 0, 1, 0, 12,  20,  0, 0, 1, 0};
      vt[7]  = '{1, 1, 0, 0, 1, 0, 11,  20,  0, 0, 1, 0};
      vt[8]  = '{1, 1, 0, 0, 0, 0, 13,  20,  0, 0, 1, 0};
      vt[9]  = '{1, 1, 0, 0, 0, 0, 14,  21,  0, 0, 0, 1};
      vt[10] = '{0, 0, 0, 0, 0, 0, 0,   0,   0, 0, 0, 0};

      // Reset with both requesting: no grants, all outputs cleared.
      reset = 0; idle_in(); req0 = 1; req1 = 1;
      addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
      step(); step();
      check("rst_gnt0", 32'(gnt0), 32'(0));
      check("rst_gnt1", 32'(gnt1), 32'(0));
      check("rst_res_rd", 32'(res_rd), 32'(0));
      check("rst_res_wr", 32'(res_wr), 32'(0));
      check("rst_res_addr", 32'(res_addr), 32'(0));
      check("rst_res_do", 32'(res_do), 32'(0));
      check("rst_rvalid", 32'({rvalid1, rvalid0}), 32'(0));
      check("rst_rdata0", 32'(rdata0), 32'(0));
      check("rst_rdata1", 32'(rdata1), 32'(0));
      reset = 1;

      // Table: tie-break after reset, then a locked burst by requester 0.
      for (int i = 0; i < NVEC; i++) begin
         req0 = vt[i].q0; req1 = vt[i].q1; we0 = vt[i].w0; we1 = vt[i].w1;
         lock0 = vt[i].l0; lock1 = vt[i].l1; addr0 = vt[i].a0; addr1 = vt[i].a1;
         wdata0 = vt[i].d0; wdata1 = vt[i].d1;
         #1;
         check($sformatf("vec%0d_gnt0", i), 32'(gnt0), 32'(vt[i].g0));
         check($sformatf("vec%0d_gnt1", i), 32'(gnt1), 32'(vt[i].g1));
         step();
         if (i == 0) check("tie_addr_first", 32'(res_addr), 32'(100));
         if (i == 1) check("tie_addr_second", 32'(res_addr), 32'(200));
      end
      step(); step();

      // Write then read-back of the same address.
      idle_in(); req0 = 1; we0 = 1; addr0 = 5; wdata0 = 8'h1F;
      step();
      check("wr_strobe", 32'(res_wr), 32'(1));
      check("wr_addr", 32'(res_addr), 32'(5));
      check("wr_data", 32'(res_do), 32'(8'h1F));
      we0 = 0;
      step();
      check("rd_strobe", 32'(res_rd), 32'(1));
      check("rd_early_valid", 32'(rvalid0), 32'(0));
      idle_in();
      step();
      check("rd_valid", 32'(rvalid0), 32'(1));
      check("rd_data", 32'(rdata0), 32'(8'h1F));
      step();
      check("rd_pulse_end", 32'(rvalid0), 32'(0));

      // Permanent lock by requester 0 while requester 1 waits.
      reset = 0; idle_in(); step(); reset = 1;
      req0 = 1; lock0 = 1; req1 = 1; addr0 = 1; addr1 = 2;
      n0 = 0; saw1 = 0;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (gnt1) begin saw1 = 1; break; end
         if (gnt0) n0++;
         step();
      end
`ifdef RES_ARB_LOCK_GUARD_EN
      check("guard_grants0", 32'(n0), 32'(MAX_LOCK));
      check("guard_gnt1", 32'(saw1), 32'(1));
`else
      check("lock_grants0", 32'(n0), 32'(20));
      check("lock_gnt1", 32'(saw1), 32'(0));
`endif
      idle_in(); step(); step(); step();

      // Reset one cycle after a read handshake kills the read.
      req0 = 1; addr0 = 7;
      step();
      reset = 0; idle_in();
      step();
      check("rstrd_rvalid0", 32'(rvalid0), 32'(0));
      check("rstrd_res_rd", 32'(res_rd), 32'(0));
      check("rstrd_res_wr", 32'(res_wr), 32'(0));
      check("rstrd_res_addr", 32'(res_addr), 32'(0));
      check("rstrd_res_do", 32'(res_do), 32'(0));
      reset = 1;
      step();
      check("rstrd_rvalid0_late", 32'(rvalid0), 32'(0));

      // Ten idle cycles: no strobes, no read data.
      for (int i = 0; i < 10; i++) begin
         step();
         check("idle_strobes", 32'({res_rd, res_wr}), 32'(0));
         check("idle_rvalid", 32'({rvalid1, rvalid0}), 32'(0));
      end

      // Randomised traffic against the model.
      for (int i = 0; i < 600; i++) begin
         reset  = ($urandom_range(0, 59) != 0);
         req0   = ($urandom_range(0, 9) < 6);
         req1   = ($urandom_range(0, 9) < 6);
         we0    = 1'($urandom_range(0, 1));
         we1    = 1'($urandom_range(0, 1));
         lock0  = ($urandom_range(0, 9) < 3);
         lock1  = ($urandom_range(0, 9) < 3);
         addr0  = AW'($urandom_range(0, 15));
         addr1  = AW'($urandom_range(0, 15));
         wdata0 = DW'($urandom);
         wdata1 = DW'($urandom);
         step();
      end
      reset = 1; idle_in();
      step(); step(); step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
